// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding imem read at a time, single-entry
// buffer toward decode, redirect handling with in-flight response dropping.
module ifetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [XLEN-1:0]    instr_pc,
  output logic [INSTR_W-1:0] instr_data,
  input  logic               instr_ready,
  output logic [XLEN-1:0]    fetch_pc,
  output logic               misaligned_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic                 drop_q, drop_d;
  logic                 req_valid_q, req_valid_d;
  logic [XLEN-1:0]      req_addr_q, req_addr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [XLEN-1:0]      instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0]   instr_data_q, instr_data_d;
  logic                 mis_err_q, mis_err_d;

  logic redir_ok;
  logic redir_bad;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Next-state: FSM transitions, PC update, drop tracking and output buffer.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;
    instr_data_d  = instr_data_q;
    mis_err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        // A redirect while the request is still pending just retargets it;
        // if the old request is accepted this cycle its response must be dropped.
        if (imem_req_ready) begin
          state_d = StWait;
          drop_d  = redir_ok;
        end
        if (redir_ok) begin
          fetch_pc_d = redirect_pc;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (drop_q || redir_ok) begin
            state_d = StReq;
            drop_d  = 1'b0;
          end else begin
            instr_pc_d    = fetch_pc_q;
            instr_data_d  = imem_rsp_data;
            instr_valid_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            state_d       = StHold;
          end
        end else if (redir_ok) begin
          drop_d = 1'b1;
        end
        if (redir_ok) begin
          fetch_pc_d = redirect_pc;
        end
      end
      StHold: begin
        // Either the handshake completes or a redirect discards the buffer.
        if ((instr_valid_q && instr_ready) || redir_ok) begin
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end
        if (redir_ok) begin
          fetch_pc_d = redirect_pc;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_q != StIdle) begin
      mis_err_d = redir_bad;
    end

    // Request outputs are registered from the next state.
    req_valid_d = (state_d == StReq);
    req_addr_d  = (state_d == StReq) ? fetch_pc_d : '0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      drop_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      instr_data_q  <= '0;
      mis_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      drop_q        <= drop_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      instr_data_q  <= instr_data_d;
      mis_err_q     <= mis_err_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = instr_valid_q;
  assign instr_pc       = instr_pc_q;
  assign instr_data     = instr_data_q;
  assign fetch_pc       = fetch_pc_q;
  assign misaligned_err = mis_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, wrap/reset sequence, random run
// against a next-accepted-PC reference model.
module tb_ifetch_unit;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_ready;

  logic        a_req_valid, b_req_valid;
  logic [63:0] a_req_addr, b_req_addr;
  logic        a_instr_valid, b_instr_valid;
  logic [63:0] a_instr_pc, b_instr_pc;
  logic [31:0] a_instr_data, b_instr_data;
  logic [63:0] a_fetch_pc, b_fetch_pc;
  logic        a_mis, b_mis;

  ifetch_unit #(.XLEN(64), .INSTR_W(32), .RESET_PC(64'd0)) u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(a_req_valid), .imem_req_addr(a_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(a_instr_valid), .instr_pc(a_instr_pc),
    .instr_data(a_instr_data), .instr_ready(instr_ready), .fetch_pc(a_fetch_pc),
    .misaligned_err(a_mis)
  );

  // Second instance runs in lockstep to cover PC wrap-around from the top.
  ifetch_unit #(.XLEN(64), .INSTR_W(32), .RESET_PC(WRAP_PC)) u_dut_wrap (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(b_instr_valid), .instr_pc(b_instr_pc),
    .instr_data(b_instr_data), .instr_ready(instr_ready), .fetch_pc(b_fetch_pc),
    .misaligned_err(b_mis)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n, rr, rv;
    logic [63:0] ra;
    logic        ir, dv;
    logic [63:0] dpc;
    logic        evq;
    logic [63:0] eaddr;
    logic        eiv;
    logic [63:0] epc, efp;
    logic        emis;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst_n, rr, rv, input logic [63:0] ra, input logic ir, dv,
                     input logic [63:0] dpc, input logic evq, input logic [63:0] eaddr,
                     input logic eiv, input logic [63:0] epc, efp, input logic emis);
    vec_t v;
    v.rst_n = rst_n; v.rr = rr; v.rv = rv; v.ra = ra; v.ir = ir; v.dv = dv; v.dpc = dpc;
    v.evq = evq; v.eaddr = eaddr; v.eiv = eiv; v.epc = epc; v.efp = efp; v.emis = emis;
    tv.push_back(v);
  endtask

  initial begin
    vec_t        v;
    logic [63:0] exp_pc, prev_pc, out_addr;
    logic [31:0] prev_data;
    bit          hold_prev, exp_mis, outstanding, pre_out, ok_r;
    int          rsp_cnt, gap, accepts;

    // Inputs held at negedge i take effect at the following posedge; expected
    // outputs are the state visible at negedge i.
    //  rst rr rv ra      ir dv dpc      evq eaddr  eiv epc     efp     emis
    add(1, 1, 0, 0,      1, 0, 0,       0, 0,      0, 0,      0,      0); // idle
    add(1, 1, 0, 0,      1, 0, 0,       1, 0,      0, 0,      0,      0);
    add(1, 1, 1, 'h0,    1, 0, 0,       0, 0,      0, 0,      0,      0);
    add(1, 1, 0, 0,      1, 0, 0,       0, 0,      1, 'h0,    'h4,    0);
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h4,    0, 0,      'h4,    0);
    add(1, 1, 1, 'h4,    1, 0, 0,       0, 0,      0, 0,      'h4,    0);
    add(1, 1, 0, 0,      1, 0, 0,       0, 0,      1, 'h4,    'h8,    0);
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h8,    0, 0,      'h8,    0);
    add(1, 1, 0, 0,      1, 1, 'h100,   0, 0,      0, 0,      'h8,    0); // redirect in WAIT
    add(1, 1, 1, 'h8,    1, 0, 0,       0, 0,      0, 0,      'h100,  0); // dropped rsp
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h100,  0, 0,      'h100,  0);
    add(1, 1, 1, 'h100,  0, 0, 0,       0, 0,      0, 0,      'h100,  0);
    for (int k = 0; k < 5; k++)
      add(1, 0, 0, 0,    0, 0, 0,       0, 0,      1, 'h100,  'h104,  0); // decode stall
    add(1, 0, 0, 0,      1, 0, 0,       0, 0,      1, 'h100,  'h104,  0);
    add(1, 1, 0, 0,      1, 1, 'h200,   1, 'h104,  0, 0,      'h104,  0); // redirect + accept
    add(1, 1, 1, 'h104,  1, 0, 0,       0, 0,      0, 0,      'h200,  0);
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h200,  0, 0,      'h200,  0);
    add(1, 1, 1, 'h200,  1, 0, 0,       0, 0,      0, 0,      'h200,  0);
    add(1, 1, 0, 0,      1, 1, 'h102,   0, 0,      1, 'h200,  'h204,  0); // misaligned
    add(1, 0, 0, 0,      1, 1, 'h300,   1, 'h204,  0, 0,      'h204,  1); // retarget in REQ
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h300,  0, 0,      'h300,  0);
    add(1, 1, 1, 'h300,  1, 1, 'h400,   0, 0,      0, 0,      'h300,  0); // rsp + redirect
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h400,  0, 0,      'h400,  0);
    add(1, 1, 1, 'h400,  1, 0, 0,       0, 0,      0, 0,      'h400,  0);
    add(1, 1, 0, 0,      0, 1, 'h500,   0, 0,      1, 'h400,  'h404,  0); // HOLD discard
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h500,  0, 0,      'h500,  0);
    add(1, 1, 1, 'h500,  1, 0, 0,       0, 0,      0, 0,      'h500,  0);
    add(1, 1, 0, 0,      1, 1, 'h600,   0, 0,      1, 'h500,  'h504,  0); // accept + redirect
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h600,  0, 0,      'h600,  0);
    add(1, 1, 0, 0,      1, 1, 'h700,   0, 0,      0, 0,      'h600,  0); // back-to-back
    add(1, 1, 0, 0,      1, 1, 'h800,   0, 0,      0, 0,      'h700,  0);
    add(1, 1, 1, 'h600,  1, 0, 0,       0, 0,      0, 0,      'h800,  0);
    add(1, 1, 0, 0,      1, 0, 0,       1, 'h800,  0, 0,      'h800,  0);
    add(0, 1, 0, 0,      1, 0, 0,       0, 0,      0, 0,      'h800,  0); // reset in WAIT
    add(1, 0, 0, 0,      1, 0, 0,       0, 0,      0, 0,      0,      0);
    add(1, 0, 0, 0,      1, 0, 0,       1, 0,      0, 0,      0,      0);

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      chk($sformatf("v%0d req_valid", i), a_req_valid, v.evq);
      chk($sformatf("v%0d req_addr", i), a_req_addr, v.eaddr);
      chk($sformatf("v%0d instr_valid", i), a_instr_valid, v.eiv);
      if (v.eiv) begin
        chk($sformatf("v%0d instr_pc", i), a_instr_pc, v.epc);
        chk($sformatf("v%0d instr_data", i), a_instr_data, data_of(v.epc));
      end
      chk($sformatf("v%0d fetch_pc", i), a_fetch_pc, v.efp);
      chk($sformatf("v%0d misaligned_err", i), a_mis, v.emis);
      if (i == 3)  chk("wrap first instr_pc", b_instr_pc, WRAP_PC);
      if (i == 4)  chk("wrap next req_addr", b_req_addr, 64'd0);
      if (i == 38) chk("wrap reset fetch_pc", b_fetch_pc, WRAP_PC);
      reset          = v.rst_n;
      imem_req_ready = v.rr;
      imem_rsp_valid = v.rv;
      imem_rsp_data  = v.rv ? data_of(v.ra) : 32'h0;
      instr_ready    = v.ir;
      redirect_valid = v.dv;
      redirect_pc    = v.dpc;
      @(negedge clk);
    end

    // Wrap-around instance fetch then reset asserted while waiting on memory.
    chk("wrap req_addr top", b_req_addr, WRAP_PC);
    imem_req_ready = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = data_of(WRAP_PC);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("wrap hold valid", b_instr_valid, 1'b1);
    chk("wrap hold pc", b_instr_pc, WRAP_PC);
    chk("wrap hold data", b_instr_data, data_of(WRAP_PC));
    chk("wrap fetch_pc", b_fetch_pc, 64'd0);
    @(negedge clk);
    chk("wrap req after", b_req_valid, 1'b1);
    chk("wrap req addr after", b_req_addr, 64'd0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst a req_valid", a_req_valid, 1'b0);
    chk("rst a req_addr", a_req_addr, 64'd0);
    chk("rst a instr_valid", a_instr_valid, 1'b0);
    chk("rst a instr_data", a_instr_data, 32'd0);
    chk("rst a fetch_pc", a_fetch_pc, 64'd0);
    chk("rst b instr_pc", b_instr_pc, 64'd0);
    chk("rst b instr_data", b_instr_data, 32'd0);
    chk("rst b fetch_pc", b_fetch_pc, WRAP_PC);
    reset = 1'b1;
    @(negedge clk);
    chk("rst b restart req", b_req_valid, 1'b1);
    chk("rst b restart addr", b_req_addr, WRAP_PC);

    // Random run: model tracks only the PC decode should accept next.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_pc = 64'd0; hold_prev = 1'b0; exp_mis = 1'b0; outstanding = 1'b0;
    rsp_cnt = 0; gap = 0; accepts = 0; out_addr = '0; prev_pc = '0; prev_data = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd misaligned_err", a_mis, exp_mis);
      if (hold_prev) begin
        chk("rnd hold valid", a_instr_valid, 1'b1);
        chk("rnd hold pc", a_instr_pc, prev_pc);
        chk("rnd hold data", a_instr_data, prev_data);
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      imem_rsp_valid = outstanding && (rsp_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? data_of(out_addr) : $urandom;
      redirect_valid = (c > 3) && ($urandom_range(0, 15) == 0);
      redirect_pc    = 64'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      ok_r = redirect_valid && (redirect_pc[1:0] == 2'b00);

      pre_out = outstanding;
      if (imem_rsp_valid) outstanding = 1'b0;
      else if (outstanding) rsp_cnt--;
      if (a_req_valid && imem_req_ready) begin
        chk("rnd single outstanding", pre_out, 1'b0);
        outstanding = 1'b1;
        out_addr    = a_req_addr;
        rsp_cnt     = $urandom_range(0, 2);
      end
      if (a_instr_valid && instr_ready) begin
        chk("rnd accept pc", a_instr_pc, exp_pc);
        chk("rnd accept data", a_instr_data, data_of(exp_pc));
        exp_pc = exp_pc + 64'd4;
        accepts++;
        gap = 0;
      end else begin
        gap++;
      end
      if (ok_r) exp_pc = redirect_pc;
      exp_mis   = redirect_valid && !ok_r;
      hold_prev = a_instr_valid && !instr_ready && !ok_r;
      prev_pc   = a_instr_pc;
      prev_data = a_instr_data;
      if (gap > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL rnd progress: no instruction accepted for %0d cycles, limit 300", gap);
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (accepts < 100) begin
      n_fail++;
      $display("FAIL rnd throughput: %0d instructions accepted, required at least 100", accepts);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
